alu_ctrl_decoder: RTL and testbench
===================================

// Module: alu_ctrl_decoder
// PURPOSE
// - Decode stage feeding the 32-bit integer ALU: turns RV32I instruction words into ALU SELECT/ROTATE codes plus operand controls.
// - Registered pipeline stage with valid/ready handshake on both sides, stall hold and flush; sits between fetch and execute.
// - ALU codes: 0 pass DATA2, 1 add, 2 and, 3 or, 4 xor, 5 xnor, 6 shift right, 7 shift left; ROTATE=1 selects arithmetic shift.
// PARAMETERS
// - DATA_WIDTH  32  instruction and immediate width
// - REG_ADDR_W  5   register index width
// PORTS
// - CLK            in   1   clock; all state on rising edge
// - RESET          in   1   synchronous, active-high reset
// - FLUSH          in   1   discard all held entries
// - INSTR_VALID    in   1   upstream word valid
// - INSTR          in   32  instruction word
// - INSTR_READY    out  1   stage can accept
// - OUT_VALID      out  1   decoded entry valid
// - OUT_READY      in   1   execute consumes entry
// - OUT_SELECT     out  3   ALU SELECT code
// - OUT_ROTATE     out  1   ALU ROTATE (1 = arithmetic shift)
// - OUT_NEG_B      out  1   execute negates DATA2 (two's complement) before ALU; SUB only
// - OUT_USE_IMM    out  1   DATA2 = OUT_IMM instead of rs2
// - OUT_IMM        out  32  sign-extended immediate (U-imm for LUI, shamt zero-extended for shifts)
// - OUT_RS1/RS2/RD out  5   register indices
// - OUT_REG_WRITE, OUT_MEM_READ, OUT_MEM_WRITE, OUT_BRANCH, OUT_BNE  out 1 each  control flags
// - OUT_ILLEGAL    out  1   unsupported/illegal encoding
// BEHAVIOUR
// - Handshake: transfer when VALID&READY at rising edge; OUT_* stable while OUT_VALID&!OUT_READY.
// - Latency 1 cycle INSTR accept -> OUT_VALID. Order preserved; no drop, no duplicate.
// - States: EMPTY -> FULL on accept; FULL -> EMPTY on consume w/o accept; FULL stays on consume+accept.
// - INSTR_READY = !OUT_VALID | OUT_READY (combinational) in base build.
// - Decode OP (0110011): f3 000/f7 00 ADD sel1; f7 20 SUB sel1 NEG_B=1; 111 AND 2; 110 OR 3; 100 XOR 4;
//   001 SLL 7/ROT0; 101 SRL 6/ROT0, f7 20 SRA 6/ROT1; REG_WRITE=1.
// - OP-IMM (0010011): same map, USE_IMM=1, no SUB; SLLI/SRLI/SRAI require imm[11:5] 00/00/20, IMM=shamt.
// - LOAD (0000011) / STORE (0100011): sel1, USE_IMM, I/S-imm; MEM_READ+REG_WRITE / MEM_WRITE.
// - LUI (0110111): sel0, USE_IMM, IMM={INSTR[31:12],12'b0}, REG_WRITE.
// - BRANCH (1100011) f3 000 BEQ / 001 BNE: sel0 (ZERO from ALU compare), BRANCH=1, BNE=f3[0], B-imm.
// - Anything else (SLT/SLTU, other branches, JAL, bad f7, unknown opcode): OUT_ILLEGAL=1,
//   SELECT=0, all write/mem/branch flags 0; still a normal handshake entry.
// - rd=x0 forces OUT_REG_WRITE=0.
// - FLUSH: all entries invalid next cycle; input word in the FLUSH cycle is taken (INSTR_READY=1) and dropped.
// - RESET (any time, incl. mid-stall): next cycle OUT_VALID=0, all OUT_* = 0, INSTR_READY=0 during RESET; RESET beats FLUSH.
// CONFIGURATION
// - ALU_DEC_SKID_EN defined: 2-entry skid buffer (states EMPTY/FULL/SKID); INSTR_READY registered,
//   =1 unless SKID; second word captured in skid while output stalls; full throughput with stall.
// - ALU_DEC_SKID_EN undefined: single entry, combinational INSTR_READY as above.
// TESTING
// - 0x002081B3 (ADD x3,x1,x2) -> next cycle OUT_VALID=1, SELECT=1, NEG_B=0, RS1=1, RS2=2, RD=3, REG_WRITE=1.
// - 0x40335293 (SRAI x5,x6,3) -> SELECT=6, ROTATE=1, USE_IMM=1, IMM=0x00000003, RD=5.
// - 0x403100B3 (SUB x1,x2,x3) -> SELECT=1, NEG_B=1, USE_IMM=0; 0x0020A1B3 (SLT) -> ILLEGAL=1, REG_WRITE=0.
// - Back-to-back ADD/SRAI/SUB, OUT_READY=0 4 cycles: outputs frozen, INSTR_READY=0 after 1 (2 w/ skid) entries; order kept.
// - FLUSH while FULL -> OUT_VALID=0 next cycle; RESET mid-stall -> OUT_VALID=0, all OUT_*=0.

Source files
------------

// File: rtl/alu_ctrl_decoder.sv
// RV32I decode stage for the integer ALU: registered entry with valid/ready on both sides.
// Optional 2-entry skid buffer with registered INSTR_READY when ALU_DEC_SKID_EN is defined.
module alu_ctrl_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  INSTR_VALID,
  input  logic [DATA_WIDTH-1:0] INSTR,
  output logic                  INSTR_READY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [2:0]            OUT_SELECT,
  output logic                  OUT_ROTATE,
  output logic                  OUT_NEG_B,
  output logic                  OUT_USE_IMM,
  output logic [DATA_WIDTH-1:0] OUT_IMM,
  output logic [REG_ADDR_W-1:0] OUT_RS1,
  output logic [REG_ADDR_W-1:0] OUT_RS2,
  output logic [REG_ADDR_W-1:0] OUT_RD,
  output logic                  OUT_REG_WRITE,
  output logic                  OUT_MEM_READ,
  output logic                  OUT_MEM_WRITE,
  output logic                  OUT_BRANCH,
  output logic                  OUT_BNE,
  output logic                  OUT_ILLEGAL
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;

  typedef struct packed {
    logic [2:0]            sel;
    logic                  rot;
    logic                  neg_b;
    logic                  use_imm;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  bne;
    logic                  illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  function automatic dec_t decode(input logic [DATA_WIDTH-1:0] ins);
    dec_t                  d;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic                  ok;
    logic                  is_reg;
    logic                  f7_ok;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] shamt;
    d      = '0;
    f3     = ins[14:12];
    f7     = ins[31:25];
    ok     = 1'b1;
    is_reg = ins[5];
    f7_ok  = (f7 == F7_BASE);
    imm_i  = {{(DATA_WIDTH-12){ins[31]}}, ins[31:20]};
    shamt  = {{(DATA_WIDTH-5){1'b0}}, ins[24:20]};
    d.rs1  = REG_ADDR_W'(ins[19:15]);
    d.rs2  = REG_ADDR_W'(ins[24:20]);
    d.rd   = REG_ADDR_W'(ins[11:7]);
    case (ins[6:0])
      OPC_OP, OPC_OP_IMM: begin
        // OP and OP-IMM share the funct3 map; bit 5 of the opcode tells them apart
        d.reg_write = 1'b1;
        d.use_imm   = !is_reg;
        d.imm       = is_reg ? '0 : imm_i;
        case (f3)
          3'b000: begin d.sel = 3'd1; d.neg_b = is_reg & (f7 == F7_ALT);
                        ok = !is_reg | f7_ok | (f7 == F7_ALT); end
          3'b111: begin d.sel = 3'd2; ok = !is_reg | f7_ok; end
          3'b110: begin d.sel = 3'd3; ok = !is_reg | f7_ok; end
          3'b100: begin d.sel = 3'd4; ok = !is_reg | f7_ok; end
          3'b001: begin d.sel = 3'd7; ok = f7_ok;
                        if (!is_reg) d.imm = shamt; end
          3'b101: begin d.sel = 3'd6; d.rot = (f7 == F7_ALT); ok = f7_ok | (f7 == F7_ALT);
                        if (!is_reg) d.imm = shamt; end
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.sel = 3'd1; d.use_imm = 1'b1; d.imm = imm_i;
        d.mem_read = 1'b1; d.reg_write = 1'b1;
      end
      OPC_STORE: begin
        d.sel = 3'd1; d.use_imm = 1'b1; d.mem_write = 1'b1;
        d.imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_LUI: begin
        d.sel = 3'd0; d.use_imm = 1'b1; d.reg_write = 1'b1;
        d.imm = {ins[DATA_WIDTH-1:12], 12'b0};
      end
      OPC_BRANCH: begin
        // equality is resolved from the ALU ZERO flag, so DATA2 is passed through
        d.sel = 3'd0; d.branch = 1'b1; d.bne = f3[0]; ok = (f3[2:1] == 2'b00);
        d.imm = {{(DATA_WIDTH-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d         = '0;
      d.illegal = 1'b1;
    end else if (ins[11:7] == 5'd0) begin
      d.reg_write = 1'b0;
    end
    return d;
  endfunction

  // Stage p0: combinational decode of the incoming word
  dec_t   dec_p0;
  logic   acc_p0;
  assign dec_p0 = decode(INSTR);
  assign acc_p0 = INSTR_VALID & INSTR_READY;

  // Stage p1: held entry, plus skid entry in the buffered build
  state_t state_q, state_d;
  dec_t   data_p1;
  dec_t   out_p1;
  logic   vld_p1;
  logic   cons_p1;
  logic   ld_main;
`ifdef ALU_DEC_SKID_EN
  dec_t   data_sk;
  logic   ld_skid;
  logic   ld_from_skid;
  logic   rdy_q;
`endif

  assign vld_p1  = (state_q != EMPTY);
  assign cons_p1 = vld_p1 & OUT_READY;

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
`ifdef ALU_DEC_SKID_EN
    ld_skid      = 1'b0;
    ld_from_skid = 1'b0;
`endif
    case (state_q)
      EMPTY: if (acc_p0) begin ld_main = 1'b1; state_d = FULL; end
      FULL: begin
        if (cons_p1) begin
          if (acc_p0) ld_main = 1'b1;
          else        state_d = EMPTY;
        end
`ifdef ALU_DEC_SKID_EN
        else if (acc_p0) begin
          ld_skid = 1'b1;
          state_d = SKID;
        end
`endif
      end
`ifdef ALU_DEC_SKID_EN
      SKID: if (cons_p1) begin ld_from_skid = 1'b1; state_d = FULL; end
`endif
      default: state_d = EMPTY;
    endcase
    if (FLUSH) state_d = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
`ifdef ALU_DEC_SKID_EN
    if (ld_from_skid) data_p1 <= data_sk;
    else if (ld_main) data_p1 <= dec_p0;
    if (ld_skid)      data_sk <= dec_p0;
`else
    if (ld_main)      data_p1 <= dec_p0;
`endif
  end

`ifdef ALU_DEC_SKID_EN
  always_ff @(posedge CLK) begin
    if (RESET) rdy_q <= 1'b1;
    else       rdy_q <= (state_d != SKID);
  end
  assign INSTR_READY = !RESET & (rdy_q | FLUSH);
`else
  assign INSTR_READY = !RESET & ((state_q == EMPTY) | OUT_READY | FLUSH);
`endif

  // Invalid entries present all-zero controls; data registers need no reset
  assign out_p1        = vld_p1 ? data_p1 : '0;
  assign OUT_VALID     = vld_p1;
  assign OUT_SELECT    = out_p1.sel;
  assign OUT_ROTATE    = out_p1.rot;
  assign OUT_NEG_B     = out_p1.neg_b;
  assign OUT_USE_IMM   = out_p1.use_imm;
  assign OUT_IMM       = out_p1.imm;
  assign OUT_RS1       = out_p1.rs1;
  assign OUT_RS2       = out_p1.rs2;
  assign OUT_RD        = out_p1.rd;
  assign OUT_REG_WRITE = out_p1.reg_write;
  assign OUT_MEM_READ  = out_p1.mem_read;
  assign OUT_MEM_WRITE = out_p1.mem_write;
  assign OUT_BRANCH    = out_p1.branch;
  assign OUT_BNE       = out_p1.bne;
  assign OUT_ILLEGAL   = out_p1.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: directed cases plus random traffic
// against a queue-based reference built from the RV32I decode rules.
module tb_alu_ctrl_decoder;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, INSTR_VALID, OUT_READY;
  logic [31:0] INSTR;
  logic        INSTR_READY, OUT_VALID;
  logic [2:0]  OUT_SELECT;
  logic        OUT_ROTATE, OUT_NEG_B, OUT_USE_IMM;
  logic [31:0] OUT_IMM;
  logic [4:0]  OUT_RS1, OUT_RS2, OUT_RD;
  logic        OUT_REG_WRITE, OUT_MEM_READ, OUT_MEM_WRITE, OUT_BRANCH, OUT_BNE, OUT_ILLEGAL;

  alu_ctrl_decoder #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .INSTR_VALID(INSTR_VALID), .INSTR(INSTR),
    .INSTR_READY(INSTR_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_SELECT(OUT_SELECT), .OUT_ROTATE(OUT_ROTATE), .OUT_NEG_B(OUT_NEG_B),
    .OUT_USE_IMM(OUT_USE_IMM), .OUT_IMM(OUT_IMM), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
    .OUT_RD(OUT_RD), .OUT_REG_WRITE(OUT_REG_WRITE), .OUT_MEM_READ(OUT_MEM_READ),
    .OUT_MEM_WRITE(OUT_MEM_WRITE), .OUT_BRANCH(OUT_BRANCH), .OUT_BNE(OUT_BNE),
    .OUT_ILLEGAL(OUT_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_SRAI = 32'h40335293;
  localparam logic [31:0] W_SUB  = 32'h403100B3;
  localparam logic [31:0] W_SLT  = 32'h0020A1B3;

  typedef struct packed {
    logic [2:0]  sel;
    logic        rot, neg, use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, br, bne, ill;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  bit          known = 0;
  bit          zero_chk = 0;
  int          sel_tbl [8] = '{1, 7, 0, 0, 4, 6, 3, 2};

  function automatic exp_t model(input logic [31:0] w);
    exp_t       e;
    logic [6:0] opc   = w[6:0];
    logic [2:0] f3    = w[14:12];
    logic [6:0] f7    = w[31:25];
    bit         alt   = (f7 == 7'h20);
    bit         base  = (f7 == 7'h00);
    bit         shift = (f3 == 3'd1) || (f3 == 3'd5);
    bit         sltx  = (f3 == 3'd2) || (f3 == 3'd3);
    bit         ok    = 0;
    e = '0;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    if (opc == 7'h33) begin
      ok = !sltx && (base || (alt && (f3 == 3'd0 || f3 == 3'd5)));
      e.sel = 3'(sel_tbl[f3]); e.neg = alt && f3 == 3'd0; e.rot = alt && f3 == 3'd5; e.rw = 1;
    end else if (opc == 7'h13) begin
      ok = !sltx && (!shift || base || (alt && f3 == 3'd5));
      e.sel = 3'(sel_tbl[f3]); e.use_imm = 1; e.rw = 1; e.rot = alt && f3 == 3'd5;
      e.imm = shift ? 32'(w[24:20]) : 32'($signed(w[31:20]));
    end else if (opc == 7'h03) begin
      ok = 1; e.sel = 3'd1; e.use_imm = 1; e.imm = 32'($signed(w[31:20])); e.mr = 1; e.rw = 1;
    end else if (opc == 7'h23) begin
      ok = 1; e.sel = 3'd1; e.use_imm = 1; e.mw = 1;
      e.imm = 32'($signed({w[31:25], w[11:7]}));
    end else if (opc == 7'h37) begin
      ok = 1; e.sel = 3'd0; e.use_imm = 1; e.rw = 1; e.imm = w & 32'hFFFFF000;
    end else if (opc == 7'h63) begin
      ok = (f3 == 3'd0) || (f3 == 3'd1); e.sel = 3'd0; e.br = 1; e.bne = f3[0];
      e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    end
    if (!ok) begin
      e = '0; e.ill = 1;
    end else if (w[11:7] == 5'd0) begin
      e.rw = 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head();
    exp_t e = model(q[0]);
    chk("illegal",   64'(OUT_ILLEGAL),   64'(e.ill));
    chk("select",    64'(OUT_SELECT),    64'(e.sel));
    chk("reg_write", 64'(OUT_REG_WRITE), 64'(e.rw));
    chk("mem_read",  64'(OUT_MEM_READ),  64'(e.mr));
    chk("mem_write", 64'(OUT_MEM_WRITE), 64'(e.mw));
    chk("branch",    64'(OUT_BRANCH),    64'(e.br));
    chk("bne",       64'(OUT_BNE),       64'(e.bne));
    if (!e.ill) begin
      chk("rotate",  64'(OUT_ROTATE),  64'(e.rot));
      chk("neg_b",   64'(OUT_NEG_B),   64'(e.neg));
      chk("use_imm", 64'(OUT_USE_IMM), 64'(e.use_imm));
      chk("imm",     64'(OUT_IMM),     64'(e.imm));
      chk("rs1",     64'(OUT_RS1),     64'(e.rs1));
      chk("rs2",     64'(OUT_RS2),     64'(e.rs2));
      chk("rd",      64'(OUT_RD),      64'(e.rd));
    end
  endtask

  task automatic zero_check(input string tag);
    chk(tag, 64'({OUT_SELECT, OUT_ROTATE, OUT_NEG_B, OUT_USE_IMM, OUT_IMM, OUT_RS1, OUT_RS2,
                  OUT_RD, OUT_REG_WRITE, OUT_MEM_READ, OUT_MEM_WRITE, OUT_BRANCH, OUT_BNE,
                  OUT_ILLEGAL}), 64'd0);
  endtask

  // One clock: drive inputs, check the current cycle against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic rs, output bit acc);
    bit exp_rdy;
    bit cons;
    INSTR_VALID = v; INSTR = w; OUT_READY = ordy; FLUSH = fl; RESET = rs;
    #1;
`ifdef ALU_DEC_SKID_EN
    exp_rdy = !rs && (q.size() < 2 || fl);
`else
    exp_rdy = !rs && (q.size() == 0 || ordy || fl);
`endif
    chk("instr_ready", 64'(INSTR_READY), 64'(exp_rdy));
    if (known) begin
      chk("out_valid", 64'(OUT_VALID), 64'(q.size() != 0));
      if (q.size() != 0) check_head();
      else if (zero_chk) zero_check("idle_zero");
    end
    acc  = v && exp_rdy;
    cons = (q.size() != 0) && ordy;
    @(posedge CLK);
    #1;
    if (rs) begin
      q.delete(); known = 1; zero_chk = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (cons) q.delete(0);
      if (acc) begin q.push_back(w); zero_chk = 0; end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 9))
      0, 1: begin w[6:0] = 7'h33; w[31:25] = f7; end
      2, 3: begin w[6:0] = 7'h13; w[31:25] = f7; end
      4:    w[6:0] = 7'h03;
      5:    w[6:0] = 7'h23;
      6:    w[6:0] = 7'h37;
      7:    w[6:0] = 7'h63;
      8:    w[6:0] = 7'h6F;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    bit          a;
    int          idx;
    logic [31:0] cur;
    logic [31:0] seqw [3];
    seqw = '{W_ADD, W_SRAI, W_SUB};

    step(0, 32'h0, 1, 0, 1, a);
    step(0, 32'h0, 1, 0, 1, a);
    step(0, 32'h0, 1, 0, 0, a);

    // Directed decode of the reference words with a free-running consumer
    step(1, W_ADD, 1, 0, 0, a);
    chk("add_valid", 64'(OUT_VALID), 64'd1);
    chk("add_sel",   64'(OUT_SELECT), 64'd1);
    chk("add_neg",   64'(OUT_NEG_B), 64'd0);
    chk("add_regs",  64'({OUT_RS1, OUT_RS2, OUT_RD}), 64'({5'd1, 5'd2, 5'd3}));
    chk("add_rw",    64'(OUT_REG_WRITE), 64'd1);
    step(1, W_SRAI, 1, 0, 0, a);
    chk("srai_sel",  64'(OUT_SELECT), 64'd6);
    chk("srai_rot",  64'(OUT_ROTATE), 64'd1);
    chk("srai_imm",  64'({OUT_USE_IMM, OUT_IMM}), 64'({1'b1, 32'h3}));
    chk("srai_rd",   64'(OUT_RD), 64'd5);
    step(1, W_SUB, 1, 0, 0, a);
    chk("sub_sel",   64'(OUT_SELECT), 64'd1);
    chk("sub_neg",   64'(OUT_NEG_B), 64'd1);
    chk("sub_useimm", 64'(OUT_USE_IMM), 64'd0);
    step(1, W_SLT, 1, 0, 0, a);
    chk("slt_ill",   64'(OUT_ILLEGAL), 64'd1);
    chk("slt_rw",    64'(OUT_REG_WRITE), 64'd0);
    step(0, 32'h0, 1, 0, 0, a);

    // Back-to-back words against a 4-cycle output stall; each word held until taken
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      step(idx < 3, seqw[idx < 3 ? idx : 0], c >= 5, 0, 0, a);
      if (a) idx++;
    end
    chk("stall_all_sent", 64'(idx), 64'd3);

    // Flush while full drops the held entry and the word offered alongside it
    step(1, W_ADD, 0, 0, 0, a);
    step(1, W_SUB, 0, 1, 0, a);
    chk("flush_valid", 64'(OUT_VALID), 64'd0);
    step(0, 32'h0, 1, 0, 0, a);

    // Reset in the middle of a stall
    step(1, W_ADD, 0, 0, 0, a);
    step(1, W_SRAI, 0, 0, 0, a);
    step(1, W_SUB, 0, 0, 1, a);
    chk("rst_stall_valid", 64'(OUT_VALID), 64'd0);
    zero_check("rst_stall_zero");
    step(0, 32'h0, 1, 0, 0, a);

    // Random traffic with random stalls, occasional flush and reset
    cur = rand_instr();
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 96) == 0, a);
      if (a) cur = rand_instr();
    end
    for (int c = 0; c < 4; c++) step(0, 32'h0, 1, 0, 0, a);
    chk("drained", 64'(OUT_VALID), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
